lvds_line_scanner: RTL and testbench

Parametrised N-channel LVDS line test driver. It drives a square-wave test pattern onto exactly one selected LVDS output line and holds all other lines low.
- Manual mode: the host chooses the line.
- Auto mode: the block steps through every line with a fixed dwell time, as a single pass or looping.
It sits between the board test controller and the LVDS output buffers of the check unit.

---
 rtl/lvds_test_pkg.sv | 16 +
 rtl/lvds_phase_gen.sv | 45 ++++
 rtl/lvds_line_scanner.sv | 143 ++++++++++++++
 tb/tb_lvds_line_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lvds_test_pkg.sv
// Shared types and constants for the LVDS line test driver.
package lvds_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   localparam int unsigned PASS_W = 16;

endpackage

// File: rtl/lvds_phase_gen.sv
// Square-wave phase divider: phase toggles every HALF_PER enabled cycles.
// Exposes the phase for the next cycle so the caller can register its outputs in step.
module lvds_phase_gen #(
   parameter int unsigned HALF_PER = 1
) (
   input  logic clk_100Mz,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic phase_nxt_c
);

   localparam int unsigned HC_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PER - 1);

   logic [HC_W-1:0] half_cnt;
   logic [HC_W-1:0] half_cnt_nxt;
   logic            phase;

   // Clear, or hold at zero when the next cycle is not an active one.
   always_comb begin
      half_cnt_nxt = '0;
      phase_nxt_c  = 1'b0;
      if (en && !clr) begin
         if (half_cnt == HC_LAST) begin
            half_cnt_nxt = '0;
            phase_nxt_c  = ~phase;
         end else begin
            half_cnt_nxt = half_cnt + HC_W'(1);
            phase_nxt_c  = phase;
         end
      end
   end

   always_ff @(posedge clk_100Mz) begin
      if (rst) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else begin
         half_cnt <= half_cnt_nxt;
         phase    <= phase_nxt_c;
      end
   end

endmodule

// File: rtl/lvds_line_scanner.sv
// N-channel LVDS line test driver: square wave on one selected line, manual or auto scan.
module lvds_line_scanner
   import lvds_test_pkg::*;
#(
   parameter int unsigned N_CH      = 8,
   parameter int unsigned CH_W      = $clog2(N_CH),
   parameter int unsigned HALF_PER  = 1,
   parameter int unsigned DWELL_CYC = 100
) (
   input  logic              clk_100Mz,
   input  logic              rst,
   input  logic              mode,
   input  logic              loop,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              start,
   input  logic              stop,
   output logic [N_CH-1:0]   lvds_out,
   output logic [CH_W-1:0]   cur_ch,
   output logic              busy,
   output logic              done,
   output logic [PASS_W-1:0] pass_cnt
);

   localparam int unsigned DW_W  = $clog2(DWELL_CYC);
   localparam int unsigned CHP_W = CH_W + 1;
   localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);
   localparam logic [CHP_W-1:0] N_CH_V  = CHP_W'(N_CH);

   state_t              state, state_nxt;
   logic [CH_W-1:0]     cur_ch_nxt;
   logic [DW_W-1:0]     dwell_cnt, dwell_nxt;
   logic [PASS_W-1:0]   pass_nxt;
   logic                loop_q, loop_nxt;
   logic                sel_ok;
   logic                clr_phase;
   logic                active_nxt;
   logic                phase_nxt;
   logic [N_CH-1:0]     lvds_nxt;

   assign sel_ok     = ({1'b0, ch_sel} < N_CH_V);
   assign active_nxt = (state_nxt == MANUAL) || (state_nxt == SCAN);

   lvds_phase_gen #(.HALF_PER(HALF_PER)) u_phase (
      .clk_100Mz   (clk_100Mz),
      .rst         (rst),
      .clr         (clr_phase),
      .en          (active_nxt),
      .phase_nxt_c (phase_nxt)
   );

   // Next state; stop outranks channel advance, which outranks start.
   always_comb begin
      state_nxt  = state;
      cur_ch_nxt = cur_ch;
      dwell_nxt  = dwell_cnt;
      pass_nxt   = pass_cnt;
      loop_nxt   = loop_q;
      clr_phase  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !stop) begin
               if (mode == MODE_AUTO) begin
                  state_nxt  = SCAN;
                  cur_ch_nxt = '0;
                  dwell_nxt  = '0;
                  pass_nxt   = '0;
                  loop_nxt   = loop;
                  clr_phase  = 1'b1;
               end else if (sel_ok) begin
                  state_nxt  = MANUAL;
                  cur_ch_nxt = ch_sel;
                  clr_phase  = 1'b1;
               end
            end
         end
         MANUAL: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (sel_ok) begin
               cur_ch_nxt = ch_sel;
            end
         end
         SCAN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (dwell_cnt == DW_LAST) begin
               dwell_nxt = '0;
               if (cur_ch != CH_LAST) begin
                  cur_ch_nxt = cur_ch + CH_W'(1);
                  clr_phase  = 1'b1;
               end else if (loop_q) begin
                  cur_ch_nxt = '0;
                  pass_nxt   = pass_cnt + PASS_W'(1);
                  clr_phase  = 1'b1;
               end else begin
                  pass_nxt  = PASS_W'(1);
                  state_nxt = DONE;
               end
            end else begin
               dwell_nxt = dwell_cnt + DW_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output pattern tracks the channel and phase of the coming cycle.
   always_comb begin
      lvds_nxt = '0;
      if (active_nxt) begin
         lvds_nxt = N_CH'(phase_nxt) << cur_ch_nxt;
      end
   end

   always_ff @(posedge clk_100Mz) begin
      if (rst) begin
         state     <= IDLE;
         cur_ch    <= '0;
         dwell_cnt <= '0;
         pass_cnt  <= '0;
         loop_q    <= 1'b0;
         lvds_out  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_ch    <= cur_ch_nxt;
         dwell_cnt <= dwell_nxt;
         pass_cnt  <= pass_nxt;
         loop_q    <= loop_nxt;
         lvds_out  <= lvds_nxt;
         busy      <= active_nxt;
         done      <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_lvds_line_scanner.sv
// Directed bench for lvds_line_scanner: 8-line and 6-line instances, queue-based expected patterns.
module tb_lvds_line_scanner;

   logic        clk_100Mz = 1'b0;
   logic        rst = 1'b1;
   logic        mode = 1'b0;
   logic        loop = 1'b0;
   logic [2:0]  ch_sel = 3'd0;
   logic        start = 1'b0;
   logic        stop = 1'b0;

   logic [7:0]  lvds8;
   logic [2:0]  cur8;
   logic        busy8, done8;
   logic [15:0] pass8;
   logic [5:0]  lvds6;
   logic [2:0]  cur6;
   logic        busy6, done6;
   logic [15:0] pass6;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   always #5 clk_100Mz = ~clk_100Mz;

   lvds_line_scanner #(.N_CH(8), .HALF_PER(2), .DWELL_CYC(10)) dut8 (
      .clk_100Mz(clk_100Mz), .rst(rst), .mode(mode), .loop(loop), .ch_sel(ch_sel),
      .start(start), .stop(stop), .lvds_out(lvds8), .cur_ch(cur8), .busy(busy8),
      .done(done8), .pass_cnt(pass8));

   lvds_line_scanner #(.N_CH(6), .HALF_PER(2), .DWELL_CYC(10)) dut6 (
      .clk_100Mz(clk_100Mz), .rst(rst), .mode(mode), .loop(loop), .ch_sel(ch_sel),
      .start(start), .stop(stop), .lvds_out(lvds6), .cur_ch(cur6), .busy(busy6),
      .done(done6), .pass_cnt(pass6));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_100Mz);
      #1;
   endtask

   // At most one line may ever be driven.
   always @(negedge clk_100Mz) begin
      if (mon_en) begin
         check("onehot8", 64'($countones(lvds8) <= 1), 64'd1);
         check("onehot6", 64'($countones(lvds6) <= 1), 64'd1);
      end
   end

   initial begin
      step();
      step();
      rst = 1'b0;
      mon_en = 1'b1;
      step();

      // Reset in the middle of a looping scan
      mode = 1'b1; loop = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (25) step();
      check("mid_busy", 64'(busy8), 64'd1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_lvds", 64'(lvds8), 64'd0);
      check("rst_cur", 64'(cur8), 64'd0);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_done", 64'(done8), 64'd0);
      check("rst_pass", 64'(pass8), 64'd0);

      // Auto single pass
      mode = 1'b1; loop = 1'b0; start = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(8'(((i / 2) % 2)));
      for (int i = 0; i < 10; i++) begin
         step();
         start = 1'b0;
         exp_v = exp_q.pop_front();
         check($sformatf("scan_ch0_%0d", i), 64'(lvds8), 64'(exp_v));
      end
      step();
      check("scan_cur_t11", 64'(cur8), 64'd1);
      check("scan_lvds_t11", 64'(lvds8), 64'd0);
      step();
      step();
      check("scan_lvds_t13", 64'(lvds8), 64'h02);
      repeat (67) step();
      check("scan_cur_t80", 64'(cur8), 64'd7);
      check("scan_done_t80", 64'(done8), 64'd0);
      step();
      check("scan_done_t81", 64'(done8), 64'd1);
      check("scan_busy_t81", 64'(busy8), 64'd0);
      check("scan_lvds_t81", 64'(lvds8), 64'd0);
      check("scan_pass_t81", 64'(pass8), 64'd1);
      step();
      check("scan_done_t82", 64'(done8), 64'd0);
      check("scan_lvds_t82", 64'(lvds8), 64'd0);

      // Auto loop, then stop
      mode = 1'b1; loop = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (79) step();
      check("loop_cur_t80", 64'(cur8), 64'd7);
      step();
      check("loop_cur_t81", 64'(cur8), 64'd0);
      check("loop_pass_t81", 64'(pass8), 64'd1);
      check("loop_busy_t81", 64'(busy8), 64'd1);
      check("loop_done_t81", 64'(done8), 64'd0);
      repeat (19) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("loop_stop_lvds", 64'(lvds8), 64'd0);
      check("loop_stop_busy", 64'(busy8), 64'd0);
      check("loop_stop_done", 64'(done8), 64'd0);
      step();
      check("loop_stop_done2", 64'(done8), 64'd0);

      // Manual on channel 5, then switch to channel 2
      mode = 1'b0; ch_sel = 3'd5; start = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(((i / 2) % 2) != 0 ? 8'h20 : 8'h00);
      for (int i = 0; i < 10; i++) begin
         step();
         start = 1'b0;
         exp_v = exp_q.pop_front();
         check($sformatf("man_ch5_%0d", i), 64'(lvds8), 64'(exp_v));
      end
      ch_sel = 3'd2;
      exp_q.push_back(8'h04);
      exp_q.push_back(8'h04);
      exp_q.push_back(8'h00);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_v = exp_q.pop_front();
         check($sformatf("man_ch2_%0d", i), 64'(lvds8), 64'(exp_v));
      end
      check("man_cur", 64'(cur8), 64'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("man_stop_busy", 64'(busy8), 64'd0);
      check("man_stop_lvds", 64'(lvds8), 64'd0);

      // Start and stop together in idle
      mode = 1'b0; ch_sel = 3'd1; start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("conf_busy", 64'(busy8), 64'd0);
      check("conf_lvds", 64'(lvds8), 64'd0);

      // Second start during a scan is ignored
      mode = 1'b1; loop = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      mode = 1'b0; ch_sel = 3'd3; start = 1'b1;
      step();
      start = 1'b0;
      check("restart_cur", 64'(cur8), 64'd0);
      check("restart_busy", 64'(busy8), 64'd1);
      repeat (5) step();
      check("restart_cur_t10", 64'(cur8), 64'd0);
      step();
      check("restart_cur_t11", 64'(cur8), 64'd1);
      stop = 1'b1;
      step();
      stop = 1'b0;

      // Out-of-range selects on the 6-line instance
      rst = 1'b1;
      step();
      rst = 1'b0;
      mode = 1'b0; ch_sel = 3'd7; start = 1'b1;
      step();
      start = 1'b0;
      check("oor_start_busy", 64'(busy6), 64'd0);
      check("oor_start_lvds", 64'(lvds6), 64'd0);
      ch_sel = 3'd4; start = 1'b1;
      step();
      start = 1'b0;
      check("oor_man_busy", 64'(busy6), 64'd1);
      check("oor_man_cur", 64'(cur6), 64'd4);
      ch_sel = 3'd6;
      step();
      check("oor_hold_cur", 64'(cur6), 64'd4);
      step();
      check("oor_hold_lvds", 64'(lvds6), 64'h10);
      ch_sel = 3'd1;
      step();
      check("oor_new_cur", 64'(cur6), 64'd1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("oor_stop_busy", 64'(busy6), 64'd0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
